// File: rtl/div_rem_unit.sv
// Multi-cycle RV32IM DIV/DIVU/REM/REMU unit: radix-2 restoring divider on operand
// magnitudes, re-signed in a final FIX cycle; fixed 33-cycle START-to-DONE latency.
module div_rem_unit (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        START,
  input  logic [1:0]  OP,
  input  logic [31:0] DIVIDEND,
  input  logic [31:0] DIVISOR,
  output logic        BUSY,
  output logic        DONE,
  output logic [31:0] RESULT
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic [31:0] origDvnd_q, origDvnd_d;
  logic [31:0] result_q, result_d;
  logic [1:0]  op_q, op_d;
  logic        negQuo_q, negQuo_d;
  logic        negRem_q, negRem_d;
  logic        divZero_q, divZero_d;
  logic        ovf_q, ovf_d;
  logic        done_q, done_d;

  logic        signedOp;
  logic        dvndNeg, dvsrNeg;
  logic [31:0] dvndMag, dvsrMag;

  logic [32:0] remShift;
  logic [31:0] quoShift;
  logic        fits;
  logic [31:0] remSub;

  logic [31:0] quoSigned, remSigned, fixResult;

  // Operand magnitudes: only the signed ops (OP[0]=0) un-negate their inputs.
  always_comb begin
    signedOp = ~OP[0];
    dvndNeg  = signedOp & DIVIDEND[31];
    dvsrNeg  = signedOp & DIVISOR[31];
    dvndMag  = dvndNeg ? (~DIVIDEND + 32'd1) : DIVIDEND;
    dvsrMag  = dvsrNeg ? (~DIVISOR + 32'd1) : DIVISOR;
  end

  // The stored remainder is always below the divisor, so after a successful
  // compare the 32-bit difference is exact even though the shifted value is 33 bits.
  always_comb begin
    remShift = {rem_q, quo_q[31]};
    quoShift = {quo_q[30:0], 1'b0};
    fits     = (remShift >= {1'b0, dvsr_q});
    remSub   = remShift[31:0] - dvsr_q;
  end

  always_comb begin
    quoSigned = negQuo_q ? (~quo_q + 32'd1) : quo_q;
    remSigned = negRem_q ? (~rem_q + 32'd1) : rem_q;
    if (divZero_q) begin
      fixResult = op_q[1] ? origDvnd_q : 32'hFFFF_FFFF;
    end else if (ovf_q) begin
      fixResult = op_q[1] ? 32'h0000_0000 : 32'h8000_0000;
    end else begin
      fixResult = op_q[1] ? remSigned : quoSigned;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    dvsr_d     = dvsr_q;
    origDvnd_d = origDvnd_q;
    result_d   = result_q;
    op_d       = op_q;
    negQuo_d   = negQuo_q;
    negRem_d   = negRem_q;
    divZero_d  = divZero_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          op_d       = OP;
          negQuo_d   = dvndNeg ^ dvsrNeg;
          negRem_d   = dvndNeg;
          divZero_d  = (DIVISOR == 32'd0);
          ovf_d      = signedOp && (DIVIDEND == 32'h8000_0000) && (DIVISOR == 32'hFFFF_FFFF);
          origDvnd_d = DIVIDEND;
          quo_d      = dvndMag;
          dvsr_d     = dvsrMag;
          rem_d      = 32'd0;
          cnt_d      = 5'd0;
          state_d    = S_CALC;
        end
      end
      S_CALC: begin
        if (fits) begin
          rem_d = remSub;
          quo_d = quoShift | 32'd1;
        end else begin
          rem_d = remShift[31:0];
          quo_d = quoShift;
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        result_d = fixResult;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= S_IDLE;
      cnt_q      <= 5'd0;
      rem_q      <= 32'd0;
      quo_q      <= 32'd0;
      dvsr_q     <= 32'd0;
      origDvnd_q <= 32'd0;
      result_q   <= 32'd0;
      op_q       <= 2'd0;
      negQuo_q   <= 1'b0;
      negRem_q   <= 1'b0;
      divZero_q  <= 1'b0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      quo_q      <= quo_d;
      dvsr_q     <= dvsr_d;
      origDvnd_q <= origDvnd_d;
      result_q   <= result_d;
      op_q       <= op_d;
      negQuo_q   <= negQuo_d;
      negRem_q   <= negRem_d;
      divZero_q  <= divZero_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign BUSY   = (state_q == S_CALC) || (state_q == S_FIX);
  assign DONE   = done_q;
  assign RESULT = result_q;

endmodule

// File: tb/tb_div_rem_unit.sv
// Self-checking bench for div_rem_unit: directed plan cases plus randomized ops
// compared against a plain-arithmetic RV32IM divide/remainder model.
module tb_div_rem_unit;

  logic        CLK;
  logic        RESET_N;
  logic        START;
  logic [1:0]  OP;
  logic [31:0] DIVIDEND;
  logic [31:0] DIVISOR;
  logic        BUSY;
  logic        DONE;
  logic [31:0] RESULT;

  int checks = 0;
  int errors = 0;

  div_rem_unit dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .START    (START),
    .OP       (OP),
    .DIVIDEND (DIVIDEND),
    .DIVISOR  (DIVISOR),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .RESULT   (RESULT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // RV32IM semantics straight from the ISA rules, using native integer arithmetic.
  function automatic logic [31:0] refDivRem(input logic [1:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    int sa;
    int sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return op[1] ? 32'h0000_0000 : 32'h8000_0000;
    case (op)
      2'b00:   return sa / sb;
      2'b01:   return a / b;
      2'b10:   return sa % sb;
      default: return a % b;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Launches one op, optionally scrambles inputs or re-pulses START while busy,
  // then watches a fixed window so extra DONE pulses would be seen too.
  task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [31:0] a,
                               input logic [31:0] b, input bit scramble, input int injectAt);
    int lat;
    int dones;
    int firstLat;
    logic [31:0] res;
    logic [31:0] expv;
    expv = refDivRem(op, a, b);
    res = 32'hxxxx_xxxx;
    @(negedge CLK);
    OP = op;
    DIVIDEND = a;
    DIVISOR = b;
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    checkOutput({tag, " busy"}, {31'd0, BUSY}, 32'd1);
    lat = 0;
    dones = 0;
    firstLat = -1;
    while (lat < 40) begin
      @(posedge CLK);
      #1;
      lat++;
      if (DONE) begin
        dones++;
        if (firstLat < 0) begin
          firstLat = lat;
          res = RESULT;
          checkOutput({tag, " busyAtDone"}, {31'd0, BUSY}, 32'd0);
        end
      end
      if (scramble && firstLat < 0) begin
        DIVIDEND = $urandom;
        DIVISOR = $urandom;
        OP = 2'($urandom_range(0, 3));
      end
      START = (injectAt > 0 && lat == injectAt);
      if (START) begin
        DIVIDEND = ~a;
        DIVISOR = b + 32'd3;
        OP = ~op;
      end
    end
    checkOutput({tag, " latency"}, firstLat, 32'd33);
    checkOutput({tag, " result"}, res, expv);
    checkOutput({tag, " donePulses"}, dones, 32'd1);
    checkOutput({tag, " held"}, RESULT, expv);
  endtask

  initial begin
    int lat;
    int dones;
    logic [1:0] rop;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] expv;

    START = 1'b0;
    OP = 2'b00;
    DIVIDEND = 32'd0;
    DIVISOR = 32'd0;
    RESET_N = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("reset busy", {31'd0, BUSY}, 32'd0);
    checkOutput("reset done", {31'd0, DONE}, 32'd0);
    checkOutput("reset result", RESULT, 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;

    applyStimulus("div -7/2", 2'b00, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
    applyStimulus("rem -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
    applyStimulus("divu", 2'b01, 32'hFFFF_FFFF, 32'h10, 1'b0, 0);
    applyStimulus("remu", 2'b11, 32'hFFFF_FFFF, 32'h10, 1'b0, 0);
    applyStimulus("div by0", 2'b00, 32'h1234_5678, 32'd0, 1'b0, 0);
    applyStimulus("divu by0", 2'b01, 32'h1234_5678, 32'd0, 1'b0, 0);
    applyStimulus("rem by0", 2'b10, 32'h1234_5678, 32'd0, 1'b0, 0);
    applyStimulus("remu by0", 2'b11, 32'h1234_5678, 32'd0, 1'b0, 0);
    applyStimulus("rem neg by0", 2'b10, 32'h8765_4321, 32'd0, 1'b0, 0);
    applyStimulus("div ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    applyStimulus("rem ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    applyStimulus("restart ignored", 2'b00, 32'd1000, 32'hFFFF_FFFD, 1'b0, 10);
    applyStimulus("scrambled inputs", 2'b10, 32'hDEAD_BEEF, 32'h0000_1234, 1'b1, 0);

    for (int i = 0; i < 16; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = 32'($urandom_range(1, 20));
        1: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 20));
        default: rb = $urandom;
      endcase
      applyStimulus($sformatf("random%0d", i), rop, ra, rb, 1'b0, 0);
    end

    // Back-to-back: START raised during the DONE cycle must be accepted next edge.
    @(negedge CLK);
    OP = 2'b00;
    DIVIDEND = 32'd1000;
    DIVISOR = 32'hFFFF_FFFD;
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    lat = 0;
    while (lat < 40 && !DONE) begin
      @(posedge CLK);
      #1;
      lat++;
    end
    checkOutput("b2b first latency", lat, 32'd33);
    checkOutput("b2b first result", RESULT, refDivRem(2'b00, 32'd1000, 32'hFFFF_FFFD));
    OP = 2'b11;
    DIVIDEND = 32'd12345;
    DIVISOR = 32'd100;
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    checkOutput("b2b accepted", {31'd0, BUSY}, 32'd1);
    lat = 1;
    while (lat < 45 && !DONE) begin
      @(posedge CLK);
      #1;
      lat++;
    end
    checkOutput("b2b spacing", lat, 32'd34);
    checkOutput("b2b second result", RESULT, refDivRem(2'b11, 32'd12345, 32'd100));

    // Reset dropped between edges during CALC cycle 15.
    @(negedge CLK);
    OP = 2'b00;
    DIVIDEND = 32'hFFFF_0000;
    DIVISOR = 32'd7;
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    repeat (14) @(posedge CLK);
    #3;
    RESET_N = 1'b0;
    #1;
    checkOutput("abort busy", {31'd0, BUSY}, 32'd0);
    checkOutput("abort done", {31'd0, DONE}, 32'd0);
    checkOutput("abort result", RESULT, 32'd0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge CLK);
      #1;
      if (DONE) dones++;
    end
    checkOutput("abort no done", dones, 32'd0);

    expv = 32'd14;
    applyStimulus("post-reset div", 2'b00, 32'd100, 32'd7, 1'b0, 0);
    checkOutput("post-reset div value", RESULT, expv);
    expv = 32'd2;
    applyStimulus("post-reset rem", 2'b10, 32'd100, 32'd7, 1'b0, 0);
    checkOutput("post-reset rem value", RESULT, expv);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
